// File: rtl/conv55_pkg.sv
// Shared constants for the 5x5 window generator and the conv5x5 datapath it feeds.
// The flattened window bus layout (tap k = r*K + c) is defined here so both sides agree.
package conv55_pkg;

  localparam int K           = 5;
  localparam int TAPS        = K * K;
  localparam int DATA_W_DFLT = 8;

  function automatic int win_bus_w(input int dw);
    return TAPS * dw;
  endfunction

  localparam int WIN_BUS_W = TAPS * DATA_W_DFLT;

  function automatic int tap_idx(input int r, input int c);
    return r * K + c;
  endfunction

endpackage

// File: rtl/conv55_line_buffer.sv
// One image line of delay: dout is the sample written IMG_W enabled cycles earlier.
// Circular storage with a wrapping pointer; contents are deliberately left unreset.
module conv55_line_buffer #(
  parameter int IMG_W  = 32,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int PW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [DATA_W-1:0] mem [IMG_W];
  logic [PW-1:0]     ptr_q, ptr_d;

  assign dout = mem[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (ptr_q == PW'(IMG_W - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/conv55_window_gen.sv
// Raster-stream to 5x5 window producer: four line buffers feed a 5x5 shift array,
// and a one-entry output register (with backpressure) presents each complete window.
module conv55_window_gen
  import conv55_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_W-1:0]               in_pix,
  input  logic                            in_valid,
  input  logic                            in_sof,
  output logic                            in_ready,
  output logic [win_bus_w(DATA_W)-1:0]    win_data,
  output logic                            win_valid,
  input  logic                            win_ready,
  output logic [$clog2(IMG_H)-1:0]        win_row,
  output logic [$clog2(IMG_W)-1:0]        win_col,
  output logic                            frame_done
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int NLB = K - 1;
  localparam int BW  = win_bus_w(DATA_W);

  logic              accept;
  logic [CW-1:0]     col_q, col_d, pix_col;
  logic [RW-1:0]     row_q, row_d, pix_row;
  logic [DATA_W-1:0] lb_in  [NLB];
  logic [DATA_W-1:0] lb_out [NLB];
  logic [DATA_W-1:0] win_q  [K][K];
  logic [DATA_W-1:0] win_d  [K][K];
  logic [BW-1:0]     win_data_q, win_data_d;
  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [RW-1:0]     win_row_q, win_row_d;
  logic [CW-1:0]     win_col_q, win_col_d;

  // The output register doubles as a one-entry skid: accept only when it is free or draining.
  assign in_ready = !win_valid_q || win_ready;
  assign accept   = in_valid && in_ready;

  for (genvar g = 0; g < NLB; g++) begin : g_lb
    if (g == 0) begin : g_head
      assign lb_in[g] = in_pix;
    end else begin : g_tail
      assign lb_in[g] = lb_out[g-1];
    end
    conv55_line_buffer #(
      .IMG_W  (IMG_W),
      .DATA_W (DATA_W)
    ) u_lb (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (lb_in[g]),
      .dout (lb_out[g])
    );
  end

  // Position of the pixel being accepted; a start-of-frame pins it to the origin.
  always_comb begin
    pix_row = in_sof ? '0 : row_q;
    pix_col = in_sof ? '0 : col_q;
    row_d   = row_q;
    col_d   = col_q;
    if (accept) begin
      if (pix_col == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (pix_row == RW'(IMG_H - 1)) ? '0 : pix_row + RW'(1);
      end else begin
        col_d = pix_col + CW'(1);
        row_d = pix_row;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_d[r][c] = win_q[r][c];
      end
    end
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      win_d[K-1][K-1] = in_pix;
      for (int r = 0; r < K - 1; r++) begin
        win_d[r][K-1] = lb_out[K-2-r];
      end
    end
  end

  always_comb begin
    win_data_d   = win_data_q;
    win_valid_d  = win_valid_q;
    frame_done_d = frame_done_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_data_d[DATA_W*tap_idx(r, c) +: DATA_W] = win_d[r][c];
        end
      end
      // A window exists only once four earlier lines and four earlier columns are present.
      win_valid_d  = (pix_row >= RW'(K - 1)) && (pix_col >= CW'(K - 1));
      frame_done_d = (pix_row == RW'(IMG_H - 1)) && (pix_col == CW'(IMG_W - 1));
      win_row_d    = pix_row - RW'(2);
      win_col_d    = pix_col - CW'(2);
    end else if (win_ready) begin
      win_valid_d  = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q        <= '0;
      col_q        <= '0;
      win_data_q   <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      win_data_q   <= win_data_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= win_d[r][c];
        end
      end
    end
  end

  assign win_data   = win_data_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;

endmodule

// File: tb/tb_conv55_window_gen.sv
// Scoreboard bench for conv55_window_gen on an 8x8 image: a frame-array reference model
// predicts each window on accept; a monitor pops and compares on every output handshake.
module tb_conv55_window_gen;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int DW    = 8;
  localparam int BW    = 25 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_pix;
  logic          in_valid;
  logic          in_sof;
  logic          in_ready;
  logic [BW-1:0] win_data;
  logic          win_valid;
  logic          win_ready;
  logic [2:0]    win_row;
  logic [2:0]    win_col;
  logic          frame_done;

  always #5 clk = ~clk;

  conv55_window_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .DATA_W (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_pix     (in_pix),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_ready   (in_ready),
    .win_data   (win_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [BW-1:0] data;
    int            row;
    int            col;
    bit            fd;
  } exp_t;

  exp_t          sbq[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_win    = 0;
  int            n_fd     = 0;
  int            exp_win  = 0;
  int            exp_fd   = 0;
  logic [DW-1:0] img [IMG_H][IMG_W];
  int            m_row    = 0;
  int            m_col    = 0;
  bit            rnd_mode = 1'b0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_row = 0;
    m_col = 0;
  endtask

  // Reference: keep the frame as a 2-D image and cut the 5x5 neighbourhood ending at (r,c).
  task automatic model_accept(input logic [DW-1:0] p, input bit sof);
    int   r;
    int   c;
    exp_t e;
    if (sof) begin
      m_row = 0;
      m_col = 0;
    end
    r = m_row;
    c = m_col;
    img[r][c] = p;
    if (r >= 4 && c >= 4) begin
      e.data = '0;
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          e.data[DW*(i*5+j) +: DW] = img[r-4+i][c-4+j];
        end
      end
      e.row = r - 2;
      e.col = c - 2;
      e.fd  = (r == IMG_H - 1) && (c == IMG_W - 1);
      sbq.push_back(e);
      exp_win++;
      if (e.fd) exp_fd++;
    end
    m_col++;
    if (m_col == IMG_W) begin
      m_col = 0;
      m_row++;
      if (m_row == IMG_H) m_row = 0;
    end
  endtask

  task automatic push_pix(input logic [DW-1:0] p, input bit sof);
    int tries = 0;
    bit done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      in_pix    = p;
      in_sof    = sof;
      in_valid  = 1'b1;
      win_ready = rnd_mode ? ($urandom_range(0, 99) < 70) : 1'b1;
      #1;
      if (in_ready) begin
        model_accept(p, sof);
        done = 1'b1;
      end
      tries++;
      if (!done && tries > 200) begin
        $display("FAIL accept_timeout: got in_ready stuck low expected accept within 200 cycles");
        $fatal(1);
      end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    win_ready = rnd_mode ? ($urandom_range(0, 99) < 70) : 1'b1;
  endtask

  task automatic stream(input int n, input int r0, input int c0, input bit sof_first);
    int            r = r0;
    int            c = c0;
    logic [DW-1:0] p;
    for (int k = 0; k < n; k++) begin
      if (rnd_mode && $urandom_range(0, 3) == 0) idle_cycle();
      p = rnd_mode ? DW'($urandom) : DW'(r * 8 + c);
      push_pix(p, sof_first && (k == 0));
      c++;
      if (c == IMG_W) begin
        c = 0;
        r = (r == IMG_H - 1) ? 0 : r + 1;
      end
    end
  endtask

  task automatic drain();
    bit empty = 1'b0;
    for (int i = 0; i < 30 && !empty; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      win_ready = 1'b1;
      #4;
      empty = (sbq.size() == 0) && (win_valid == 1'b0);
    end
    check("drain_complete", BW'(empty), BW'(1));
  endtask

  always @(negedge clk) begin
    exp_t e;
    #3;
    if (win_valid === 1'b1 && win_ready === 1'b1) begin
      n_win++;
      if (frame_done === 1'b1) n_fd++;
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_window: got window row %0d col %0d expected none", win_row, win_col);
      end else begin
        e = sbq.pop_front();
        check("win_data",   win_data,        e.data);
        check("win_row",    BW'(win_row),    BW'(e.row));
        check("win_col",    BW'(win_col),    BW'(e.col));
        check("frame_done", BW'(frame_done), BW'(e.fd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] held;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_pix    = '0;
    win_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_win_valid",  BW'(win_valid),  BW'(0));
    check("rst_frame_done", BW'(frame_done), BW'(0));
    check("rst_win_data",   win_data,        BW'(0));
    check("rst_win_row",    BW'(win_row),    BW'(0));
    check("rst_win_col",    BW'(win_col),    BW'(0));
    check("rst_in_ready",   BW'(in_ready),   BW'(1));
    model_reset();

    // Frame 1: first window right after pixel (4,4).
    stream(37, 0, 0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #1;
    check("first_valid", BW'(win_valid),             BW'(1));
    check("first_tap0",  BW'(win_data[DW*0  +: DW]), BW'(0));
    check("first_tap4",  BW'(win_data[DW*4  +: DW]), BW'(4));
    check("first_tap12", BW'(win_data[DW*12 +: DW]), BW'(18));
    check("first_tap20", BW'(win_data[DW*20 +: DW]), BW'(32));
    check("first_tap24", BW'(win_data[DW*24 +: DW]), BW'(36));
    check("first_row",   BW'(win_row),               BW'(2));
    check("first_col",   BW'(win_col),               BW'(2));
    stream(27, 4, 5, 1'b0);

    // Frame 2 back-to-back, stalled on the window after (5,6).
    stream(47, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_pix    = DW'(47);
      in_sof    = 1'b0;
      in_valid  = 1'b1;
      win_ready = 1'b0;
      #1;
      if (i == 0) held = win_data;
      check("stall_in_ready",  BW'(in_ready),              BW'(0));
      check("stall_win_valid", BW'(win_valid),             BW'(1));
      check("stall_tap24",     BW'(win_data[DW*24 +: DW]), BW'(46));
      check("stall_hold",      win_data,                   held);
    end
    stream(17, 5, 7, 1'b0);
    drain();
    check("win_count_2frames", BW'(n_win), BW'(32));

    // Frame 3: aborted by in_sof at (3,2), then a full frame.
    stream(26, 0, 0, 1'b1);
    stream(64, 0, 0, 1'b1);

    // Frame 4: reset after (5,5), then restart without in_sof.
    stream(46, 0, 0, 1'b1);
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    win_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_win_valid",  BW'(win_valid),  BW'(0));
    check("midrst_frame_done", BW'(frame_done), BW'(0));
    check("midrst_in_ready",   BW'(in_ready),   BW'(1));
    model_reset();
    stream(64, 0, 0, 1'b0);

    // Frame 5: random pixels, random input gaps and random output backpressure.
    rnd_mode = 1'b1;
    stream(64, 0, 0, 1'b1);
    rnd_mode = 1'b0;
    drain();

    check("sb_empty",        BW'(sbq.size()), BW'(0));
    check("win_count_model", BW'(n_win),      BW'(exp_win));
    check("win_count_total", BW'(n_win),      BW'(86));
    check("fd_count_model",  BW'(n_fd),       BW'(exp_fd));
    check("fd_count_total",  BW'(n_fd),       BW'(5));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv55_window_gen.md
Name: conv55_window_gen

Overview:
- Streaming producer for the 5x5 convolution datapath.
- Accepts a raster-order 8-bit pixel stream, buffers four image lines, and emits one 25-tap window per accepted pixel once a full 5x5 neighbourhood exists.
- The flattened window bus connects directly to the conv5x5 data inputs (tap k drives in_data_k).
- Kernel taps are out of scope.

Parameters:
- IMG_W, 32, image width in pixels (>= 5).
- IMG_H, 32, image height in lines (>= 5).
- DATA_W, 8, pixel width in bits.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- in_pix  in  DATA_W  incoming pixel.
- in_valid  in  1  in_pix valid.
- in_sof  in  1  start of frame; meaningful only with in_valid.
- in_ready  out  1  block can accept a pixel this cycle.
- win_data  out  25*DATA_W  window; tap k = bits [DATA_W*k+DATA_W-1 : DATA_W*k], k = r*5+c, r=0 oldest line, c=0 oldest column.
- win_valid  out  1  win_data valid.
- win_ready  in  1  downstream accepts the window.
- win_row  out  $clog2(IMG_H)  row of window centre (row of newest pixel minus 2).
- win_col  out  $clog2(IMG_W)  column of window centre (column of newest pixel minus 2).
- frame_done  out  1  asserted with the last window of a frame.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Accept condition: accept = in_valid && in_ready. Stall rule: in_ready = !win_valid || win_ready, so the output register acts as a one-entry skid.
- Position counters col (0..IMG_W-1) and row (0..IMG_H-1) hold the position of the next pixel. They advance only on accept.
  - col wraps at IMG_W-1 and increments row.
  - row wraps at IMG_H-1 to 0, i.e. the next frame.
- in_sof on accept forces the accepted pixel to position (0,0). Counters then continue from (0,1). A mid-frame in_sof discards the partial frame; no frame_done is produced for it.
- Line buffers: four IMG_W-deep delay lines lb0..lb3, all enabled by accept.
  - lb0 input is in_pix; lbN input is lb(N-1) output.
  - Line buffers are not reset.
- Window array: 5x5 registers. On accept every row shifts one column toward c=0, and the new c=4 column is loaded as:
  - row 4 = in_pix
  - row 3 = lb0 out
  - row 2 = lb1 out
  - row 1 = lb2 out
  - row 0 = lb3 out
- Output register, on accept of a pixel at (r,c):
  - win_valid is set next cycle iff r >= 4 and c >= 4; otherwise it is cleared next cycle. Latency is 1 cycle from accept to win_valid.
  - win_row = r-2, win_col = c-2.
  - frame_done = (r == IMG_H-1 && c == IMG_W-1).
- Window count: exactly (IMG_W-4)*(IMG_H-4) windows per frame. No windows straddle a row boundary.
- Hold rule: when win_valid && !win_ready, win_data, win_row, win_col and frame_done hold; no accept occurs.
- Drain rule: when win_valid && win_ready and no new accept, win_valid and frame_done clear next cycle.
- frame_done is a single-cycle-per-handshake flag. It is qualified by win_valid and persists while the window is stalled.
- Reset values: win_valid=0, frame_done=0, win_data=0, win_row=0, win_col=0, row=col=0, window registers = 0. in_ready is 1 one cycle after reset releases.
- Reset mid-frame: the frame in progress is abandoned. The next accepted pixel is (0,0) regardless of in_sof.
- Arithmetic: no arithmetic on pixel data; data is passed through unmodified. Counter compares use the full width of the counter.

Decomposition:
- Shared package conv55_pkg holds:
  - K=5, TAPS=25, DATA_W default 8.
  - Tap-index helper function (r*K+c).
  - The flattened-bus width constant TAPS*DATA_W, shared with conv5x5.
- Sub-module conv55_line_buffer: one IMG_W-deep, DATA_W-wide delay line with a shift enable. It is a register chain or a circular RAM with a wrapping pointer, instantiated four times.

Test Plan (IMG_W=8, IMG_H=8, pixel value = r*8+c, win_ready=1 unless stated):
- Reset, then stream one full frame with in_sof on the first pixel -> first win_valid one cycle after accepting pixel 36 (4,4):
  - tap0=0, tap4=4, tap12=18, tap20=32, tap24=36.
  - win_row=2, win_col=2.
- Same frame -> exactly 16 windows. The last has tap24=63, win_row=5, win_col=5 and frame_done=1. No window is emitted for c<4 or r<4.
- Hold win_ready=0 for 3 cycles on the window after pixel (5,6) -> in_ready=0, win_data is stable (tap24=46), no pixel is accepted. The window then completes its handshake when win_ready returns to 1.
- Back-to-back frames with in_sof each -> the second frame's first window again appears at (4,4) with tap24=36 and tap0=0, with no stale window before it.
- In_sof asserted at mid-frame position (3,2) -> the counter restarts; no frame_done for the aborted frame. The first window appears after 36 further pixels.
- Assert rst for 1 cycle after pixel (5,5) -> win_valid=0 the next cycle. The frame then restarts at (0,0) with no in_sof, and the first window appears after 37 pixels.
